// File: rtl/reg_file_if.sv
// ----------------------------------------------------------------------------
// reg_file_if
//   Bundle of the register-file access signals between the pipeline and the
//   RV32I register file.
//   master : drives read indices (rs1/rs2), write index/data/enable (WB),
//            receives both read data words.
//   slave  : the register file itself.
//   Signals:
//     rd_addr0/rd_addr1  read port indices
//     wr_addr0           write port index
//     wr_din0            write data
//     we0                write enable
//     rd_dout0/rd_dout1  read port data
// ----------------------------------------------------------------------------
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rd_addr0;
  logic [ADDR_WIDTH-1:0] rd_addr1;
  logic [ADDR_WIDTH-1:0] wr_addr0;
  logic [DATA_WIDTH-1:0] wr_din0;
  logic                  we0;
  logic [DATA_WIDTH-1:0] rd_dout0;
  logic [DATA_WIDTH-1:0] rd_dout1;

  modport master (
    output rd_addr0, rd_addr1, wr_addr0, wr_din0, we0,
    input  rd_dout0, rd_dout1
  );

  modport slave (
    input  rd_addr0, rd_addr1, wr_addr0, wr_din0, we0,
    output rd_dout0, rd_dout1
  );
endinterface

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
//   RV32I integer register file: 2**ADDR_WIDTH registers of DATA_WIDTH bits,
//   two combinational read ports, one synchronous write port. x0 reads as
//   zero and never stores a value. The array is built from flops so the
//   asynchronous reset can clear every register at once.
//
//   Ports:
//     clk  in   rising-edge clock for all state updates
//     rst  in   asynchronous, active-high; clears the whole array
//     rf   slave modport of reg_file_if (read/write ports, see interface)
//
//   Optional feature (macro REGFILE_WR_BYPASS_EN):
//     defined   - a read of the register being written in the same cycle
//                 returns wr_din0 combinationally (WB->ID bypass).
//     undefined - reads always return stored contents; new value appears
//                 only after the write edge.
// ----------------------------------------------------------------------------
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave rf
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Entry 0 is cleared by reset and never written, so it stays zero; the
  // read path still forces zero for index 0 independently of the array.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_fire;
  assign wr_fire = rf.we0 && (rf.wr_addr0 != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_fire) begin
      mem[rf.wr_addr0] <= rf.wr_din0;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] addr
  );
    logic [DATA_WIDTH-1:0] val;
    if (addr == '0) begin
      val = '0;
    end else begin
      val = mem[addr];
`ifdef REGFILE_WR_BYPASS_EN
      // A write landing on this register this cycle wins over the stored
      // value; rst gating keeps reads at zero throughout reset.
      if (!rst && wr_fire && (rf.wr_addr0 == addr)) begin
        val = rf.wr_din0;
      end
`endif
    end
    return val;
  endfunction

  assign rf.rd_dout0 = read_port(rf.rd_addr0);
  assign rf.rd_dout1 = read_port(rf.rd_addr1);

endmodule

// File: tb/tb_reg_file.sv
// ----------------------------------------------------------------------------
// tb_reg_file
//   Scoreboard bench for reg_file. The stimulus process computes the
//   expected read data from a plain array model of the 32 registers and
//   queues it; a monitor on the falling clock edge pops and compares
//   against both read ports.
// ----------------------------------------------------------------------------
module tb_reg_file;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf ();

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] e0;
    logic [31:0] e1;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Expected read value from the architectural rules.
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (rst) return 32'd0;
`ifdef REGFILE_WR_BYPASS_EN
    if (rf.we0 && rf.wr_addr0 != 5'd0 && rf.wr_addr0 == a) return rf.wr_din0;
`endif
    return model[a];
  endfunction

  function automatic void push_exp(input string name);
    exp_t e;
    e.name = name;
    e.e0   = m_read(rf.rd_addr0);
    e.e1   = m_read(rf.rd_addr1);
    sb_q.push_back(e);
  endfunction

  // Monitor: read ports are combinational, so data is "presented" for the
  // whole cycle; sample it mid-cycle on the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      if (rf.rd_dout0 !== e.e0) begin
        n_fail++;
        $display("FAIL %s port0: got %08h expected %08h", e.name, rf.rd_dout0, e.e0);
      end
      n_checks++;
      if (rf.rd_dout1 !== e.e1) begin
        n_fail++;
        $display("FAIL %s port1: got %08h expected %08h", e.name, rf.rd_dout1, e.e1);
      end
    end
  end

  // Called just after a rising edge: apply inputs, queue expectation,
  // advance one edge, update the model with whatever the edge committed.
  task automatic drive(input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [4:0] wa, input logic [31:0] din,
                       input logic we, input string name);
    rf.rd_addr0 = ra0;
    rf.rd_addr1 = ra1;
    rf.wr_addr0 = wa;
    rf.wr_din0  = din;
    rf.we0      = we;
    #1;
    push_exp(name);
    @(posedge clk);
    if (!rst && we && wa != 5'd0) model[wa] = din;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    rst         = 1'b1;
    rf.rd_addr0 = '0;
    rf.rd_addr1 = '0;
    rf.wr_addr0 = '0;
    rf.wr_din0  = '0;
    rf.we0      = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Held in reset: reads zero, writes ignored.
    drive(5'd3, 5'd31, 5'd3, 32'hFFFF_FFFF, 1'b1, "rst_hold");
    drive(5'd3, 5'd17, 5'd17, 32'h1234_0000, 1'b1, "rst_hold2");
    rst = 1'b0;
    drive(5'd3, 5'd17, 5'd0, 32'h0, 1'b0, "post_rst");

    // Basic write/read on both ports.
    drive(5'd0, 5'd0, 5'd3, 32'h1234_5678, 1'b1, "wr_x3");
    drive(5'd3, 5'd3, 5'd0, 32'h0, 1'b0, "rd_x3");

    // x0 protection.
    drive(5'd0, 5'd3, 5'd0, 32'hFFFF_FFFF, 1'b1, "wr_x0");
    drive(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, "rd_x0");

    // Disabled write.
    drive(5'd7, 5'd3, 5'd7, 32'hA5A5_A5A5, 1'b0, "we_off");
    drive(5'd7, 5'd7, 5'd0, 32'h0, 1'b0, "rd_x7");

    // Dual port, extreme indices.
    drive(5'd0, 5'd0, 5'd1, 32'h0000_0011, 1'b1, "wr_x1");
    drive(5'd0, 5'd0, 5'd31, 32'h0000_001F, 1'b1, "wr_x31");
    drive(5'd1, 5'd31, 5'd0, 32'h0, 1'b0, "dual_rd");

    // Same-cycle read/write of one register.
    drive(5'd0, 5'd0, 5'd4, 32'h0000_0004, 1'b1, "wr_x4");
    drive(5'd4, 5'd4, 5'd4, 32'h0000_0044, 1'b1, "rw_x4");
    drive(5'd4, 5'd1, 5'd0, 32'h0, 1'b0, "rd_x4");

    // Asynchronous reset between edges, with a pending write discarded.
    drive(5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF, 1'b1, "wr_x5");
    drive(5'd5, 5'd1, 5'd0, 32'h0, 1'b0, "rd_x5");
    rf.rd_addr0 = 5'd5;
    rf.rd_addr1 = 5'd9;
    rf.wr_addr0 = 5'd9;
    rf.wr_din0  = 32'h0BAD_F00D;
    rf.we0      = 1'b1;
    #1;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #1;
    push_exp("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(5'd5, 5'd9, 5'd0, 32'h0, 1'b0, "after_rst");

    // Randomized traffic, biased toward a small register set so reads
    // hit recent writes and same-cycle collisions happen often.
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  ra0, ra1, wa;
      logic [31:0] din;
      logic        we;
      ra0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      din = $urandom;
      we  = ($urandom_range(0, 3) != 0);
      drive(ra0, ra1, wa, din, we, "random");
    end

    // Sweep every register on both ports.
    for (int i = 0; i < 32; i++) begin
      drive(5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0, "sweep");
    end

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
